// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: drives the ECP5 EHXPLLL dynamic phase-shift port.
// Accepts step requests, emits timed active-low PHASESTEP pulses on the
// selected channel, tracks net phase per channel and filters PLL lock into
// pll_ok / rst_out.
module pll_phase_ctrl #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned STEP_W      = 8,
  parameter int unsigned POS_W       = 8,
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned SETTLE      = 16,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      locked_in,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_chan,
  input  logic                      req_dir,
  input  logic [STEP_W-1:0]         req_steps,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                phasesel,
  output logic                      phasedir,
  output logic                      phasestep,
  output logic                      phaseloadreg,
  output logic                      pll_ok,
  output logic                      rst_out,
  output logic [CHANNELS*POS_W-1:0] phase_pos
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StPulse  = 3'd2;
  localparam logic [2:0] StSettle = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam int unsigned LockW  = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned CntMax = (PULSE_LEN > SETTLE) ? PULSE_LEN : SETTLE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [LockW-1:0] LockTarget = LockW'(LOCK_CYCLES);
  localparam logic [CntW-1:0]  PulseLast  = CntW'(PULSE_LEN - 1);
  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE - 1);
  localparam logic [2:0]       ChanLimit  = 3'(CHANNELS);

  // Lock filter state
  logic             lock_meta_q, lock_sync_q;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic             pll_ok_q, rst_out_q;

  // Sequencer state
  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [1:0]        chan_q, chan_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic              phasestep_q;
  logic              step_done;
  logic              chan_ok;
  logic [POS_W-1:0]  pos_q [CHANNELS];
  logic [POS_W-1:0]  pos_d [CHANNELS];

  // Saturating lock counter; any synchronised low restarts the qualification.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!lock_sync_q) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LockTarget) begin
      lock_cnt_d = lock_cnt_q + LockW'(1);
    end
  end

  // Lock synchroniser, counter, pll_ok and the registered system reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      lock_cnt_q  <= '0;
      pll_ok_q    <= 1'b0;
      rst_out_q   <= 1'b1;
    end else begin
      lock_meta_q <= locked_in;
      lock_sync_q <= lock_meta_q;
      lock_cnt_q  <= lock_cnt_d;
      pll_ok_q    <= (lock_cnt_d == LockTarget);
      rst_out_q   <= !pll_ok_q;
    end
  end

  assign chan_ok = ({1'b0, chan_q} < ChanLimit);

  // Sequencer next state; loss of lock mid-request aborts straight to done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    chan_d    = chan_q;
    dir_d     = dir_q;
    err_d     = err_q;
    step_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          chan_d  = req_chan;
          dir_d   = req_dir;
          rem_d   = req_steps;
          err_d   = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d = '0;
        if (!pll_ok_q || !chan_ok) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (rem_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (!pll_ok_q) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (cnt_q == PulseLast) begin
          step_done = 1'b1;
          rem_d     = rem_q - STEP_W'(1);
          cnt_d     = '0;
          state_d   = StSettle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSettle: begin
        if (!pll_ok_q) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = (rem_q != '0) ? StPulse : StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Only a pulse that ran its full length moves the channel's position.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      pos_d[n] = pos_q[n];
      if (step_done && (chan_q == 2'(n))) begin
        pos_d[n] = dir_q ? pos_q[n] + POS_W'(1) : pos_q[n] - POS_W'(1);
      end
    end
  end

  // Sequencer registers; phasestep is registered from next state to stay glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      chan_q      <= 2'd0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      phasestep_q <= 1'b1;
      for (int n = 0; n < CHANNELS; n++) pos_q[n] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      chan_q      <= chan_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      phasestep_q <= (state_d != StPulse);
      for (int n = 0; n < CHANNELS; n++) pos_q[n] <= pos_d[n];
    end
  end

  // Output mapping
  always_comb begin
    phase_pos = '0;
    for (int n = 0; n < CHANNELS; n++) phase_pos[n*POS_W +: POS_W] = pos_q[n];
  end

  assign req_ready    = (state_q == StIdle) && pll_ok_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign err          = done && err_q;
  assign phasesel     = chan_q;
  assign phasedir     = dir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = 1'b1;
  assign pll_ok       = pll_ok_q;
  assign rst_out      = rst_out_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: the driver pushes expected completions,
// a negedge monitor pops them when done pulses.
module tb_pll_phase_ctrl;

  localparam int CH = 3;
  localparam int SW = 8;
  localparam int PW = 8;
  localparam int P  = 4;
  localparam int S  = 16;
  localparam int L  = 8;

  logic              clk = 1'b0;
  logic              reset, locked_in, req_valid, req_ready, req_dir;
  logic [1:0]        req_chan;
  logic [SW-1:0]     req_steps;
  logic              busy, done, err, phasedir, phasestep, phaseloadreg, pll_ok, rst_out;
  logic [1:0]        phasesel;
  logic [CH*PW-1:0]  phase_pos;

  pll_phase_ctrl #(
    .CHANNELS(CH), .STEP_W(SW), .POS_W(PW), .PULSE_LEN(P), .SETTLE(S), .LOCK_CYCLES(L)
  ) dut (
    .clk(clk), .reset(reset), .locked_in(locked_in), .req_valid(req_valid),
    .req_ready(req_ready), .req_chan(req_chan), .req_dir(req_dir), .req_steps(req_steps),
    .busy(busy), .done(done), .err(err), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .phaseloadreg(phaseloadreg), .pll_ok(pll_ok),
    .rst_out(rst_out), .phase_pos(phase_pos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [1:0]       chan;
    logic             dir;
    logic             err;
    int               lat;     // -1: not checked (aborted)
    int               pulses;
    logic [CH*PW-1:0] pos;
    int               t_acc;
  } exp_t;

  exp_t sbq[$];
  int   model_pos[CH];

  // Monitor: pulse counting/width and scoreboard comparison on done.
  int pulses = 0;
  int run    = 0;
  bit prev_step = 1'b1;
  bit width_bad = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pulses = 0; run = 0; prev_step = 1'b1; width_bad = 1'b0;
    end else begin
      if (phasestep == 1'b0) begin
        if (prev_step) pulses++;
        run++;
      end else begin
        if (!prev_step && run != P) width_bad = 1'b1;
        run = 0;
      end
      prev_step = phasestep;
      if (done) begin
        chk("done_expected", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("err", 64'(err), 64'(e.err));
          if (e.lat >= 0) begin
            chk("done_latency", 64'(cyc - e.t_acc + 1), 64'(e.lat));
            chk("pulse_width", 64'(width_bad), 64'd0);
          end
          chk("pulse_count", 64'(pulses), 64'(e.pulses));
          chk("phase_pos", 64'(phase_pos), 64'(e.pos));
          chk("phasesel", 64'(phasesel), 64'(e.chan));
          chk("phasedir", 64'(phasedir), 64'(e.dir));
        end
        pulses = 0; width_bad = 1'b0;
      end
    end
  end

  function automatic logic [CH*PW-1:0] pos_vec();
    logic [CH*PW-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[c*PW +: PW] = PW'(model_pos[c]);
    return v;
  endfunction

  // Issue one request; done_steps < 0 means all steps complete normally.
  task automatic issue(input int ch, input int d, input int n, input int done_steps,
                       input int exp_pulses, output int t_acc);
    exp_t e;
    int   waited = 0;
    bit   acc = 1'b0;
    bit   bad;
    int   k;
    @(negedge clk);
    req_valid = 1'b1; req_chan = 2'(ch); req_dir = d[0]; req_steps = SW'(n);
    t_acc = 0;
    while (!acc && waited < 3000) begin
      if (req_ready) begin acc = 1'b1; t_acc = cyc + 1; end
      else begin @(negedge clk); waited++; end
    end
    chk("accept_in_time", 64'(acc), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    bad = (ch >= CH);
    k   = bad ? 0 : ((done_steps < 0) ? n : done_steps);
    if (!bad) model_pos[ch] = (((model_pos[ch] + (d != 0 ? k : -k)) % 256) + 256) % 256;
    e.chan   = 2'(ch);
    e.dir    = d[0];
    e.err    = bad || (done_steps >= 0);
    e.lat    = (done_steps >= 0) ? -1 : ((bad || n == 0) ? 2 : 2 + n * (P + S));
    e.pulses = (done_steps >= 0) ? exp_pulses : k;
    e.pos    = pos_vec();
    e.t_acc  = t_acc;
    if (acc) sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && w < 3000) begin @(negedge clk); w++; end
    chk("idle_in_time", 64'(w < 3000), 64'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_phasesel"}, 64'(phasesel), 64'd0);
    chk({tag, "_phasedir"}, 64'(phasedir), 64'd0);
    chk({tag, "_phasestep"}, 64'(phasestep), 64'd1);
    chk({tag, "_phaseloadreg"}, 64'(phaseloadreg), 64'd1);
    chk({tag, "_pll_ok"}, 64'(pll_ok), 64'd0);
    chk({tag, "_rst_out"}, 64'(rst_out), 64'd1);
    chk({tag, "_phase_pos"}, 64'(phase_pos), 64'd0);
  endtask

  initial begin
    int t, k, w;
    reset = 1'b1; locked_in = 1'b0; req_valid = 1'b0;
    req_chan = 2'd0; req_dir = 1'b0; req_steps = '0;
    for (int c = 0; c < CH; c++) model_pos[c] = 0;

    repeat (3) @(posedge clk);
    #1 chk_reset_outs("rst");
    @(negedge clk) reset = 1'b0;

    // Lock qualification: pll_ok after L+2 edges, rst_out one later.
    @(negedge clk) locked_in = 1'b1;
    repeat (L + 1) @(posedge clk);
    #1 chk("pll_ok_early", 64'(pll_ok), 64'd0);
    @(posedge clk); #1;
    chk("pll_ok_rise", 64'(pll_ok), 64'd1);
    chk("rst_out_lag", 64'(rst_out), 64'd1);
    @(posedge clk); #1;
    chk("rst_out_release", 64'(rst_out), 64'd0);

    // Directed requests
    issue(2, 1, 3, -1, 0, t);
    wait_idle();
    issue(1, 0, 0, -1, 0, t);
    wait_idle();
    issue(3, 1, 2, -1, 0, t);
    wait_idle();
    issue(0, 0, 1, -1, 0, t);
    wait_idle();
    chk("wrap_down", 64'(phase_pos[0 +: PW]), 64'd255);
    issue(0, 1, 2, -1, 0, t);
    wait_idle();
    chk("wrap_up", 64'(phase_pos[0 +: PW]), 64'd1);

    // Randomised back-to-back requests
    for (int i = 0; i < 12; i++) begin
      int ch, d, n;
      ch = $urandom_range(0, 3);
      d  = $urandom_range(0, 1);
      n  = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 3);
      issue(ch, d, n, -1, 0, t);
    end
    wait_idle();

    // Lock loss during the second pulse of a 5-step request
    issue(1, 1, 5, 1, 2, t);
    w = 0;
    while (cyc != t + 21 && w < 100) begin @(negedge clk); w++; end
    chk("abort_in_pulse", 64'(phasestep), 64'd0);
    locked_in = 1'b0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (phasestep == 1'b0 && k < 10);
    chk("abort_step_release", 64'(k <= 4), 64'd1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("abort_ready_low", 64'(req_ready), 64'd0);
    chk("abort_rst_out", 64'(rst_out), 64'd1);
    locked_in = 1'b1;
    repeat (L + 3) @(negedge clk);
    chk("relock", 64'(pll_ok), 64'd1);

    // Reset in the middle of SETTLE with a request held valid
    issue(0, 1, 3, -1, 0, t);
    w = 0;
    while (cyc != t + 8 && w < 100) begin @(negedge clk); w++; end
    reset = 1'b1;
    sbq.delete();
    for (int c = 0; c < CH; c++) model_pos[c] = 0;
    req_valid = 1'b1; req_chan = 2'd2; req_dir = 1'b1; req_steps = SW'(1);
    @(posedge clk);
    #1 chk_reset_outs("midrst");
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk("held_req_not_taken", 64'(busy), 64'd0);
    end
    issue(2, 1, 1, -1, 0, t);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
